// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes and datapath select codes.
// Pure declarations: no logic, no latency, no handshake.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR2, S_LUI, S_AUIPC, S_HALT
  } state_t;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_WD  = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

endpackage

// File: rtl/alu_decoder.sv
// Maps ALU op class plus funct3/funct7[5] to ALUControl.
// Purely combinational, zero latency, no handshake.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  aluop_t     aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       is_rtype_i,
  output logic [3:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      default: begin
        case (funct3_i)
          // funct7[5] on an I-type add is just an immediate bit, never a subtract
          3'b000:  alu_ctrl_o = (is_rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_o = ALU_SLL;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b011:  alu_ctrl_o = ALU_SLTU;
          3'b100:  alu_ctrl_o = ALU_XOR;
          3'b101:  alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: 3-5 cycles per instruction, stalls in FETCH/MEMREAD/MEMWRITE until MemReady.
// Optional CTRL_HALT_ON_SYSTEM_EN parks the FSM in a sticky HALT on SYSTEM opcodes.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        cout,
  input  logic        overflow,
  input  logic        sign,
  input  logic        MemReady,
  output logic [2:0]  ImmSrc,
  output logic [3:0]  ALUControl,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        illegal,
  output logic        halted
);

  state_t     state_q, state_d;
  aluop_t     aluop;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       taken;
  logic       ir_we, pc_we, reg_we, mem_we, ill;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign funct7b5          = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = sign ^ overflow;
      3'b101:  taken = !(sign ^ overflow);
      3'b110:  taken = !cout;
      3'b111:  taken = cout;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ImmSrc    = IMM_I;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_WD;
    ResultSrc = RES_ALUOUT;
    AdrSrc    = 1'b0;
    aluop     = ALUOP_ADD;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    ill       = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALURESULT;
        ir_we     = MemReady;
        pc_we     = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch/jump target is precomputed into ALUOut here
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
`ifdef CTRL_HALT_ON_SYSTEM_EN
          OP_SYSTEM:         state_d = S_HALT;
`else
          OP_SYSTEM: begin
            state_d = S_FETCH;
            ill     = 1'b1;
          end
`endif
          default: begin
            state_d = S_FETCH;
            ill     = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_we    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_we = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_A;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_A;
        aluop   = ALUOP_SUB;
        pc_we   = taken;
        state_d = S_FETCH;
      end
      S_JAL, S_JALR2: begin
        // PC takes the target in ALUOut while OldPC+4 becomes the link value
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_4;
        pc_we   = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        state_d = S_JALR2;
      end
      S_LUI: begin
        ImmSrc    = IMM_U;
        ResultSrc = RES_IMMEXT;
        reg_we    = 1'b1;
        state_d   = S_FETCH;
      end
      S_AUIPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
        state_d = S_ALUWB;
      end
`ifdef CTRL_HALT_ON_SYSTEM_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop_i    (aluop),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .is_rtype_i (opcode == OP_RTYPE),
    .alu_ctrl_o (ALUControl)
  );

  // Reset masks every side effect in the same cycle it is asserted
  assign IRWrite  = ir_we  & reset;
  assign PCWrite  = pc_we  & reset;
  assign RegWrite = reg_we & reset;
  assign MemWrite = mem_we & reset;
  assign illegal  = ill    & reset;

`ifdef CTRL_HALT_ON_SYSTEM_EN
  assign halted = reset && (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle tables of inputs and masked expected control words.
// Drives on the falling edge and samples 1 time unit later.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, Zero, cout, overflow, sign, MemReady;
  logic [31:0] instr;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic        AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal, halted;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .instr(instr), .Zero(Zero), .cout(cout), .overflow(overflow),
    .sign(sign), .MemReady(MemReady), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .illegal(illegal), .halted(halted)
  );

  // {ImmSrc, ALUControl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IR, PC, Reg, Mem, illegal, halted}
  wire [19:0] ctl = {ImmSrc, ALUControl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
                     IRWrite, PCWrite, RegWrite, MemWrite, illegal, halted};

  localparam logic [19:0] F_IMM = 20'hE0000, F_ALU = 20'h1E000, F_SA = 20'h01800;
  localparam logic [19:0] F_SB  = 20'h00600, F_RES = 20'h00180, F_ADR = 20'h00040, F_EN = 20'h0003F;
  localparam logic [19:0] M_FETCH = F_ADR | F_SA | F_SB | F_ALU | F_RES | F_EN;
  localparam logic [19:0] M_DEC   = F_SA | F_SB | F_ALU | F_IMM | F_EN;
  localparam logic [19:0] M_EXEC  = F_SA | F_SB | F_ALU | F_EN;
  localparam logic [19:0] M_EXIM  = M_EXEC | F_IMM;
  localparam logic [19:0] M_BR    = M_EXEC | F_RES;
  localparam logic [19:0] M_MEM   = F_ADR | F_RES | F_EN;
  localparam logic [19:0] M_WB    = F_RES | F_EN;
  localparam logic [19:0] M_LUI   = F_IMM | F_RES | F_EN;
  localparam logic [19:0] M_EN    = F_EN;

  localparam logic [5:0] EN_0 = 6'b000000, EN_F = 6'b110000, EN_PC = 6'b010000, EN_RW = 6'b001000;
  localparam logic [5:0] EN_MW = 6'b000100, EN_ILL = 6'b000010, EN_HLT = 6'b000001;

  typedef struct packed {
    logic        rst;
    logic        mr;
    logic [31:0] ins;
    logic [19:0] exp;
    logic [19:0] msk;
  } row_t;

  function automatic logic [19:0] pk(input logic [2:0] imm, input logic [3:0] alu,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] res, input logic adr, input logic [5:0] en);
    return {imm, alu, sa, sb, res, adr, en};
  endfunction

  function automatic row_t r(input logic rst, input logic mr, input logic [31:0] ins,
                             input logic [19:0] exp, input logic [19:0] msk);
    row_t x;
    x.rst = rst; x.mr = mr; x.ins = ins; x.exp = exp; x.msk = msk;
    return x;
  endfunction

  function automatic row_t fetch(input logic mr, input logic [31:0] ins);
    return r(1'b1, mr, ins, pk(3'b000, ALU_ADD, 2'b00, 2'b10, 2'b10, 1'b0, mr ? EN_F : EN_0), M_FETCH);
  endfunction

  function automatic row_t decode(input logic [31:0] ins, input logic [2:0] imm, input logic [5:0] en);
    return r(1'b1, 1'b1, ins, pk(imm, ALU_ADD, 2'b01, 2'b01, 2'b00, 1'b0, en), M_DEC);
  endfunction

  function automatic row_t aluwb(input logic [31:0] ins);
    return r(1'b1, 1'b1, ins, pk(3'b000, ALU_ADD, 2'b00, 2'b00, 2'b00, 1'b0, EN_RW), M_WB);
  endfunction

  task automatic test_reset();
    row_t q[$];
    q.push_back(r(1'b0, 1'b1, 32'h00500093, pk(0, 0, 0, 0, 0, 0, EN_0), M_EN));
    q.push_back(r(1'b0, 1'b1, 32'h00500093, pk(0, 0, 0, 0, 0, 0, EN_0), M_EN));
    q.push_back(fetch(1'b0, 32'h00500093));
    foreach (q[i]) begin
      reset = q[i].rst; MemReady = q[i].mr; instr = q[i].ins;
      #1; checks++;
      if ((ctl & q[i].msk) !== (q[i].exp & q[i].msk)) begin
        errors++;
        $display("FAIL reset row %0d: got %h expected %h", i, ctl & q[i].msk, q[i].exp & q[i].msk);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_addi();
    row_t q[$];
    logic [31:0] ins = 32'h00500093;
    q.push_back(fetch(1'b1, ins));
    q.push_back(decode(ins, IMM_B, EN_0));
    q.push_back(r(1'b1, 1'b1, ins, pk(IMM_I, ALU_ADD, 2'b10, 2'b01, 0, 0, EN_0), M_EXIM));
    q.push_back(aluwb(ins));
    q.push_back(fetch(1'b0, ins));
    foreach (q[i]) begin
      reset = q[i].rst; MemReady = q[i].mr; instr = q[i].ins;
      #1; checks++;
      if ((ctl & q[i].msk) !== (q[i].exp & q[i].msk)) begin
        errors++;
        $display("FAIL addi row %0d: got %h expected %h", i, ctl & q[i].msk, q[i].exp & q[i].msk);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_funct();
    row_t q[$];
    logic [31:0] ins [4];
    logic [3:0]  alu [4];
    logic        rty [4];
    ins[0] = 32'h40208033; alu[0] = ALU_SUB; rty[0] = 1'b1;  // sub
    ins[1] = 32'h4020D033; alu[1] = ALU_SRA; rty[1] = 1'b1;  // sra
    ins[2] = 32'h4010D093; alu[2] = ALU_SRA; rty[2] = 1'b0;  // srai
    ins[3] = 32'h40008093; alu[3] = ALU_ADD; rty[3] = 1'b0;  // addi, imm bit 30 set
    for (int k = 0; k < 4; k++) begin
      q.push_back(fetch(1'b1, ins[k]));
      q.push_back(decode(ins[k], IMM_B, EN_0));
      if (rty[k]) q.push_back(r(1'b1, 1'b1, ins[k], pk(0, alu[k], 2'b10, 2'b00, 0, 0, EN_0), M_EXEC));
      else        q.push_back(r(1'b1, 1'b1, ins[k], pk(IMM_I, alu[k], 2'b10, 2'b01, 0, 0, EN_0), M_EXIM));
      q.push_back(aluwb(ins[k]));
    end
    q.push_back(fetch(1'b0, ins[3]));
    foreach (q[i]) begin
      reset = q[i].rst; MemReady = q[i].mr; instr = q[i].ins;
      #1; checks++;
      if ((ctl & q[i].msk) !== (q[i].exp & q[i].msk)) begin
        errors++;
        $display("FAIL funct row %0d: got %h expected %h", i, ctl & q[i].msk, q[i].exp & q[i].msk);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    row_t q[$];
    logic [31:0] ins [4];
    logic        tk  [4];
    ins[0] = 32'h00208463; tk[0] = 1'b1;  // beq, Zero=1
    ins[1] = 32'h00209463; tk[1] = 1'b0;  // bne, Zero=1
    ins[2] = 32'h0020C463; tk[2] = 1'b1;  // blt, sign^overflow=1
    ins[3] = 32'h0020E463; tk[3] = 1'b0;  // bltu, cout=1
    Zero = 1'b1; sign = 1'b1; overflow = 1'b0; cout = 1'b1;
    for (int k = 0; k < 4; k++) begin
      q.push_back(fetch(1'b1, ins[k]));
      q.push_back(decode(ins[k], IMM_B, EN_0));
      q.push_back(r(1'b1, 1'b1, ins[k], pk(0, ALU_SUB, 2'b10, 2'b00, 2'b00, 0, tk[k] ? EN_PC : EN_0), M_BR));
    end
    q.push_back(fetch(1'b0, ins[3]));
    foreach (q[i]) begin
      reset = q[i].rst; MemReady = q[i].mr; instr = q[i].ins;
      #1; checks++;
      if ((ctl & q[i].msk) !== (q[i].exp & q[i].msk)) begin
        errors++;
        $display("FAIL branch row %0d: got %h expected %h", i, ctl & q[i].msk, q[i].exp & q[i].msk);
      end
      @(negedge clk);
    end
    Zero = 1'b0; sign = 1'b0; cout = 1'b0;
  endtask

  task automatic test_load();
    row_t q[$];
    logic [31:0] ins = 32'h0000A283;
    q.push_back(fetch(1'b1, ins));
    q.push_back(decode(ins, IMM_B, EN_0));
    q.push_back(r(1'b1, 1'b1, ins, pk(IMM_I, ALU_ADD, 2'b10, 2'b01, 0, 0, EN_0), M_EXIM));
    q.push_back(r(1'b1, 1'b0, ins, pk(0, 0, 0, 0, 2'b00, 1'b1, EN_0), M_MEM));
    q.push_back(r(1'b1, 1'b0, ins, pk(0, 0, 0, 0, 2'b00, 1'b1, EN_0), M_MEM));
    q.push_back(r(1'b1, 1'b1, ins, pk(0, 0, 0, 0, 2'b00, 1'b1, EN_0), M_MEM));
    q.push_back(r(1'b1, 1'b1, ins, pk(0, 0, 0, 0, 2'b01, 1'b0, EN_RW), M_WB));
    q.push_back(fetch(1'b0, ins));
    foreach (q[i]) begin
      reset = q[i].rst; MemReady = q[i].mr; instr = q[i].ins;
      #1; checks++;
      if ((ctl & q[i].msk) !== (q[i].exp & q[i].msk)) begin
        errors++;
        $display("FAIL load row %0d: got %h expected %h", i, ctl & q[i].msk, q[i].exp & q[i].msk);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store();
    row_t q[$];
    logic [31:0] ins = 32'h0020A223;
    q.push_back(fetch(1'b1, ins));
    q.push_back(decode(ins, IMM_B, EN_0));
    q.push_back(r(1'b1, 1'b1, ins, pk(IMM_S, ALU_ADD, 2'b10, 2'b01, 0, 0, EN_0), M_EXIM));
    q.push_back(r(1'b1, 1'b0, ins, pk(0, 0, 0, 0, 2'b00, 1'b1, EN_MW), M_MEM));
    q.push_back(r(1'b1, 1'b1, ins, pk(0, 0, 0, 0, 2'b00, 1'b1, EN_MW), M_MEM));
    q.push_back(fetch(1'b0, ins));
    foreach (q[i]) begin
      reset = q[i].rst; MemReady = q[i].mr; instr = q[i].ins;
      #1; checks++;
      if ((ctl & q[i].msk) !== (q[i].exp & q[i].msk)) begin
        errors++;
        $display("FAIL store row %0d: got %h expected %h", i, ctl & q[i].msk, q[i].exp & q[i].msk);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jumps();
    row_t q[$];
    logic [31:0] lui = 32'h123452B7, jal = 32'h008000EF, jalr = 32'h000080E7, auipc = 32'h00001097;
    q.push_back(fetch(1'b1, lui));
    q.push_back(decode(lui, IMM_B, EN_0));
    q.push_back(r(1'b1, 1'b1, lui, pk(IMM_U, 0, 0, 0, 2'b11, 0, EN_RW), M_LUI));
    q.push_back(fetch(1'b1, jal));
    q.push_back(decode(jal, IMM_J, EN_0));
    q.push_back(r(1'b1, 1'b1, jal, pk(0, ALU_ADD, 2'b01, 2'b10, 2'b00, 0, EN_PC), M_BR));
    q.push_back(aluwb(jal));
    q.push_back(fetch(1'b1, jalr));
    q.push_back(decode(jalr, IMM_B, EN_0));
    q.push_back(r(1'b1, 1'b1, jalr, pk(IMM_I, ALU_ADD, 2'b10, 2'b01, 0, 0, EN_0), M_EXIM));
    q.push_back(r(1'b1, 1'b1, jalr, pk(0, ALU_ADD, 2'b01, 2'b10, 2'b00, 0, EN_PC), M_BR));
    q.push_back(aluwb(jalr));
    q.push_back(fetch(1'b1, auipc));
    q.push_back(decode(auipc, IMM_B, EN_0));
    q.push_back(r(1'b1, 1'b1, auipc, pk(IMM_U, ALU_ADD, 2'b01, 2'b01, 0, 0, EN_0), M_EXIM));
    q.push_back(aluwb(auipc));
    q.push_back(fetch(1'b0, auipc));
    foreach (q[i]) begin
      reset = q[i].rst; MemReady = q[i].mr; instr = q[i].ins;
      #1; checks++;
      if ((ctl & q[i].msk) !== (q[i].exp & q[i].msk)) begin
        errors++;
        $display("FAIL jumps row %0d: got %h expected %h", i, ctl & q[i].msk, q[i].exp & q[i].msk);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal_reset();
    row_t q[$];
    logic [31:0] bad = 32'h0000007F, add = 32'h00208033;
    q.push_back(fetch(1'b1, bad));
    q.push_back(r(1'b1, 1'b1, bad, pk(0, 0, 0, 0, 0, 0, EN_ILL), M_EN));
    q.push_back(fetch(1'b1, add));
    q.push_back(decode(add, IMM_B, EN_0));
    q.push_back(r(1'b0, 1'b1, add, pk(0, 0, 0, 0, 0, 0, EN_0), M_EN));
    q.push_back(fetch(1'b0, add));
    foreach (q[i]) begin
      reset = q[i].rst; MemReady = q[i].mr; instr = q[i].ins;
      #1; checks++;
      if ((ctl & q[i].msk) !== (q[i].exp & q[i].msk)) begin
        errors++;
        $display("FAIL illegal_reset row %0d: got %h expected %h", i, ctl & q[i].msk, q[i].exp & q[i].msk);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ecall();
    row_t q[$];
    logic [31:0] ins = 32'h00000073;
    q.push_back(fetch(1'b1, ins));
`ifdef CTRL_HALT_ON_SYSTEM_EN
    q.push_back(r(1'b1, 1'b1, ins, pk(0, 0, 0, 0, 0, 0, EN_0), M_EN));
    for (int k = 0; k < 20; k++)
      q.push_back(r(1'b1, 1'b1, ins, pk(0, 0, 0, 0, 0, 0, EN_HLT), M_EN));
    q.push_back(r(1'b0, 1'b1, ins, pk(0, 0, 0, 0, 0, 0, EN_0), M_EN));
`else
    q.push_back(r(1'b1, 1'b1, ins, pk(0, 0, 0, 0, 0, 0, EN_ILL), M_EN));
`endif
    q.push_back(fetch(1'b0, ins));
    foreach (q[i]) begin
      reset = q[i].rst; MemReady = q[i].mr; instr = q[i].ins;
      #1; checks++;
      if ((ctl & q[i].msk) !== (q[i].exp & q[i].msk)) begin
        errors++;
        $display("FAIL ecall row %0d: got %h expected %h", i, ctl & q[i].msk, q[i].exp & q[i].msk);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b0; MemReady = 1'b0; instr = 32'h0;
    Zero = 1'b0; cout = 1'b0; overflow = 1'b0; sign = 1'b0;
    @(negedge clk);
    test_reset();
    test_addi();
    test_funct();
    test_branch();
    test_load();
    test_store();
    test_jumps();
    test_illegal_reset();
    test_ecall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32I datapath. Decodes the latched instruction word and sequences each instruction through fetch, decode, execute, memory and writeback. Drives every datapath select and enable: PC, IR, register file, ALU operand muxes, result mux and address mux. Evaluates branch conditions from the ALU flags, and stalls on a memory ready handshake.

## Interface
Parameters:
- none. All encodings come from the shared package.

Ports:
- `clk`  in  1  system clock; every state change happens on the rising edge.
- `reset`  in  1  synchronous, active-low reset (asserted when 0, sampled on `clk`).
- `instr`  in  32  latched instruction; uses opcode [6:0], funct3 [14:12] and funct7[5] (bit 30).
- `Zero`, `cout`, `overflow`, `sign`  in  1 each  ALU flags for the current ALUResult.
- `MemReady`  in  1  memory has completed the current access.
- `ImmSrc`  out  3  immediate format: I=000, S=001, B=010, U=011, J=100.
- `ALUControl`  out  4  ALU operation select.
- `ALUSrcA`  out  2  operand A select: 00 PC, 01 OldPC, 10 A.
- `ALUSrcB`  out  2  operand B select: 00 WriteData, 01 ImmExt, 10 constant 4.
- `ResultSrc`  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt.
- `AdrSrc`  out  1  address select: 0 PC, 1 Result.
- `IRWrite`, `PCWrite`, `RegWrite`, `MemWrite`  out  1 each  datapath and memory enables.
- `illegal`  out  1  one-cycle pulse when an unsupported opcode is decoded.
- `halted`  out  1  controller is parked in HALT.

## Operation
- Moore FSM; outputs are decoded from the state. Exceptions: PCWrite in BRANCH depends on the flags, and IRWrite/PCWrite in FETCH are gated by MemReady.
- States and transitions:
  - FETCH: AdrSrc=0, SrcA=PC, SrcB=4, add, ResultSrc=10, IRWrite=PCWrite=MemReady. Stays in FETCH while !MemReady, otherwise goes to DECODE.
  - DECODE: SrcA=OldPC, SrcB=Imm, add (branch/jump target into ALUOut); ImmSrc=J for jal, B otherwise. Dispatch by opcode:
    - 0000011 → MEMADR
    - 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → AUIPC
    - any other opcode → FETCH with `illegal`=1.
  - MEMADR: SrcA=A, SrcB=Imm, add; ImmSrc is S for stores, I for loads. Goes to MEMREAD or MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Holds until MemReady, then goes to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite. Then FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Holds until MemReady, then FETCH.
  - EXECR / EXECI: SrcA=A, SrcB=WriteData (EXECR) or Imm with ImmSrc I (EXECI); ALU op from funct decode. Then ALUWB.
  - ALUWB: ResultSrc=00, RegWrite. Then FETCH.
  - BRANCH: SrcA=A, SrcB=WriteData, sub, ResultSrc=00, PCWrite=taken. Then FETCH.
  - JAL: ResultSrc=00, PCWrite; SrcA=OldPC, SrcB=4, add. Then ALUWB.
  - JALR: SrcA=A, SrcB=Imm (I), add. Then JALR2.
  - JALR2: ResultSrc=00, PCWrite; OldPC+4. Then ALUWB. Bit 0 of the target is not cleared.
  - LUI: ImmSrc=U, ResultSrc=11, RegWrite. Then FETCH.
  - AUIPC: SrcA=OldPC, SrcB=Imm (U), add. Then ALUWB.
- Branch taken condition, by funct3:
  - 000 Zero
  - 001 !Zero
  - 100 sign^overflow
  - 101 !(sign^overflow)
  - 110 !cout
  - 111 cout
  - 010 or 011: not taken.
- Funct decode, by funct3:
  - 000 add; sub only when R-type and funct7[5]=1.
  - 001 sll
  - 010 slt
  - 011 sltu
  - 100 xor
  - 101 srl, or sra when funct7[5]=1
  - 110 or
  - 111 and

## Timing
- While reset=0: state forced to FETCH, all enables forced to 0, `illegal`=0, `halted`=0. The first fetch is issued on the cycle after reset deasserts.
- Reset asserted mid-instruction: no enable fires in that cycle, and the partial instruction is abandoned.
- Cycles per instruction with MemReady=1:
  - lui 3, branch 3
  - R-type 4, I-type 4, store 4, jal 4, auipc 4
  - load 5, jalr 5
- Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle. Select outputs hold steady through the stall.
- MemWrite stays asserted through a stall. IR and PC update only on the FETCH cycle with MemReady=1.

## Configuration
- `CTRL_HALT_ON_SYSTEM_EN` defined: opcode 1110011 in DECODE goes to HALT. In HALT all enables are 0 and `halted`=1. HALT is sticky until reset.
- Macro undefined: 1110011 is treated as illegal (`illegal` pulse, return to FETCH). `halted` is tied to 0.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - state enum
  - opcode constants
  - ImmSrc, ALUSrcA/B, ResultSrc codes
  - ALUControl codes: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, sll 0111, srl 1000, sra 1001
- One sub-module, `alu_decoder`: combinational mapping of funct3, funct7[5], R/I type and ALUOp class to ALUControl. The FSM and branch evaluation live in the top module.

## Test plan
- addi x1,x0,5 (0x00500093), MemReady=1 → FETCH, DECODE, EXECI, ALUWB. ALUControl=0000, RegWrite high only in cycle 4, back in FETCH at cycle 5.
- beq with Zero=1, then bne with Zero=1 → PCWrite=1 in BRANCH for beq; PCWrite=0 for bne. Both return to FETCH after 3 cycles.
- lw with MemReady low for 2 cycles in MEMREAD → state holds, AdrSrc=1 throughout. MEMWB RegWrite with ResultSrc=01. Total 7 cycles.
- sw with MemReady delayed 1 cycle → MemWrite high for 2 consecutive cycles, then FETCH. RegWrite never asserted.
- Opcode 0x7F decoded → `illegal` pulses exactly 1 cycle and the next state is FETCH. Then reset pulled low during EXECR → next cycle FETCH with all enables 0.
- ecall (0x00000073): with macro → `halted`=1, stays there through 20 cycles, cleared by reset. Without macro → `illegal` pulse.
